// File: rtl/pipe_reg_chain_if.sv
// Valid/ready handshake bundle for pipe_reg_chain: upstream (in_*) and downstream (out_*) sides.
interface pipe_reg_chain_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapse, stall on backpressure,
// synchronous flush and a registered occupancy count.
module pipe_reg_chain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    pipe_reg_chain_if.slave       bus,
    output logic [CNT_W-1:0]      count
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             chain;
    logic             acc_in;
    logic             acc_out;

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        adv   = '0;
        chain = ~v[DEPTH-1] | bus.out_ready;
        adv[DEPTH-1] = chain;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            chain  = ~v[i] | chain;
            adv[i] = chain;
        end
    end

    assign bus.in_ready  = adv[0] & ~flush & rst_n;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign acc_in        = bus.in_valid & bus.in_ready;
    assign acc_out       = v[DEPTH-1] & bus.out_ready;

    // Valid bits and occupancy; flush empties the chain but leaves data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            count <= '0;
        end else if (flush) begin
            v     <= '0;
            count <= '0;
        end else begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i]) v[i] <= v[i-1];
            end
            if (adv[0]) v[0] <= acc_in;
            case ({acc_in, acc_out})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data moves only alongside a valid word, so empty slots keep stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) d[i] <= '0;
        end else if (!flush) begin
            if (adv[0] && acc_in) d[0] <= bus.in_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i] && v[i-1]) d[i] <= d[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=4).
module tb_pipe_reg_chain;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [CNT_W-1:0] count;

    int n_assert;
    int n_fail;

    pipe_reg_chain_if #(.WIDTH(WIDTH)) bus ();

    pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 2 time units after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_count",     32'(count),         32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        tick();
        rst_n = 1'b1;

        // 1: single word latency through an empty chain
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        #1;
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("t1_count_e1", 32'(count), 32'd1);
        for (int e = 1; e < 4; e++) begin
            chk("t1_early_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_out_data",  32'(bus.out_data),  32'hA5);
        tick();
        chk("t1_valid_gone", 32'(bus.out_valid), 32'd0);
        chk("t1_count_end",  32'(count),         32'd0);

        // 2: fill under backpressure, then drain in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        begin
            int nxt;
            nxt = 1;
            for (int c = 0; c < 6; c++) begin
                bus.in_data = 8'(nxt);
                #1;
                chk("t2_in_ready", 32'(bus.in_ready), (c < 4) ? 32'd1 : 32'd0);
                tick();
                if (c < 4) nxt++;
            end
        end
        bus.in_valid = 1'b0;
        chk("t2_count_full", 32'(count), 32'd4);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t2_drain_valid", 32'(bus.out_valid), 32'd1);
            chk("t2_drain_data",  32'(bus.out_data),  32'(k));
            chk("t2_drain_count", 32'(count),         32'(5 - k));
            tick();
        end
        chk("t2_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("t2_empty_count", 32'(count),         32'd0);

        // 3: full chain with simultaneous in/out for 10 cycles
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            bus.in_data = 8'(16 + j);
            tick();
        end
        chk("t3_full_count", 32'(count), 32'd4);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            bus.in_data = 8'(20 + j);
            #1;
            chk("t3_in_ready",  32'(bus.in_ready),  32'd1);
            chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_out_data",  32'(bus.out_data),  32'(16 + j));
            chk("t3_count",     32'(count),         32'd4);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("t3_tail_data", 32'(bus.out_data), 32'(26 + j));
            tick();
        end
        chk("t3_end_count", 32'(count), 32'd0);

        // 4: two words separated by a bubble collapse under backpressure
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h22;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_count",     32'(count),         32'd2);
        chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_first",     32'(bus.out_data),  32'h11);
        bus.out_ready = 1'b1;
        tick();
        chk("t4_second_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_second",       32'(bus.out_data),  32'h22);
        tick();
        chk("t4_drained", 32'(bus.out_valid), 32'd0);

        // 5: flush while words are held and a new word is offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bus.in_data = 8'(49 + j);
            tick();
        end
        chk("t5_count_pre", 32'(count), 32'd3);
        flush       = 1'b1;
        bus.in_data = 8'h99;
        #1;
        chk("t5_in_ready_flush", 32'(bus.in_ready), 32'd0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_count_post", 32'(count),         32'd0);
        chk("t5_valid_post", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h44;
        tick();
        bus.in_valid = 1'b0;
        for (int e = 1; e < 4; e++) begin
            chk("t5_early_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        chk("t5_new_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_new_data",  32'(bus.out_data),  32'h44);
        tick();

        // 6: asynchronous reset mid-stream
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h50;
        tick();
        bus.in_data = 8'h51;
        tick();
        chk("t6_count_pre", 32'(count), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid",    32'(bus.out_valid), 32'd0);
        chk("t6_rst_count",    32'(count),         32'd0);
        chk("t6_rst_in_ready", 32'(bus.in_ready),  32'd0);
        bus.in_valid = 1'b0;
        tick();
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h66;
        tick();
        bus.in_valid = 1'b0;
        for (int e = 1; e < 4; e++) begin
            chk("t6_early_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        chk("t6_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_out_data",  32'(bus.out_data),  32'h66);
        tick();
        chk("t6_end_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
